// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bit counter only has to reach width-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bf.sv
// Single-bit full adder cell used as the arithmetic core of the serial adder.
module FA_BF (
  output logic Sum,
  output logic Carry,
  input  logic A,
  input  logic B,
  input  logic C
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB-first, one bit per clock,
// registered parallel result with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  FA_BF u_fa (
    .Sum   (fa_sum),
    .Carry (fa_carry),
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C     (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
          carry <= fa_carry;
          cnt   <= cnt + CW'(1);
          // Last bit: publish the completed word, which still has one bit in flight.
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum_out <= {fa_sum, s_sh[WIDTH-1:1]};
            cout    <= fa_carry;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
